draw_end_banner: RTL and testbench
==================================

DRAW_END_BANNER -- requirements
Module: draw_end_banner

Interface
REQ-001 SHALL have parameters, one per line:
- NUM_RECT, 8: number of banner rectangles.
- BLINK_FRAMES, 30: frames per blink phase; 0 disables blinking.
- COLOR_P1, 12'h820: banner colour when gameover = 2'b01.
- COLOR_P2, 12'h028: banner colour when gameover = 2'b10.
- COLOR_DRAW, 12'h888: banner colour when gameover = 2'b11.
REQ-002 SHALL have ports, one per line:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- reset  in  1  game restart; clears the latched game-over.
- gameover  in  2  winner code; 0 means game running.
- rect_we  in  1  rectangle table write strobe.
- rect_idx  in  $clog2(NUM_RECT)  rectangle index to write.
- rect_en  in  1  enable bit for the written rectangle.
- rect_x0, rect_x1  in  11 each  horizontal bounds.
- rect_y0, rect_y1  in  11 each  vertical bounds.
- in  vga_if.in  -  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb.
- out  vga_if.out  -  same fields.

Function
REQ-003 SHALL delay all timing fields (vcount, vsync, vblnk, hcount, hsync, hblnk) by exactly 2 clk cycles to out.
REQ-004 SHALL use stage 1 to register the timing fields, in.rgb and the per-rectangle hit vector; stage 2 SHALL register the rgb mux result.
REQ-005 Rect i hit SHALL be: en_i && x0_i < hcount < x1_i && y0_i < vcount < y1_i (strict, unsigned). A rectangle with x0 >= x1 or y0 >= y1 SHALL never hit.
REQ-006 A rect_we write SHALL update entry rect_idx on the next clk edge; a write with rect_idx >= NUM_RECT SHALL be ignored.
REQ-007 Frame boundary SHALL be the in.vblnk rising edge (0 in the previous cycle, 1 now).
REQ-008 FSM states SHALL be IDLE, ARMED, SHOW_ON and SHOW_OFF.
REQ-009 Transitions:
- IDLE -> ARMED when gameover != 0; the code is latched into win_q.
- ARMED -> SHOW_ON at the next frame boundary.
- SHOW_ON <-> SHOW_OFF toggle when the frame counter reaches BLINK_FRAMES-1 at a frame boundary; the counter then wraps to 0.
REQ-010 With BLINK_FRAMES = 0, SHALL remain in SHOW_ON and never enter SHOW_OFF.
REQ-011 In ARMED or SHOW_*, changes on gameover SHALL be ignored; win_q SHALL hold until reset or rst.
REQ-012 reset = 1 SHALL force IDLE, clear win_q and clear the frame counter on the next edge from any state. reset SHALL take priority over a simultaneous gameover != 0 or frame boundary.
REQ-013 The frame counter SHALL count only in SHOW_ON/SHOW_OFF, SHALL be width $clog2(BLINK_FRAMES+1) (minimum 1), and SHALL be cleared on entry to SHOW_ON from ARMED.
REQ-014 Stage 2 rgb SHALL be the banner colour, selected by win_q, when the state is SHOW_ON and any rectangle hits. Otherwise it SHALL be the delayed in.rgb.
REQ-015 The state used for the rgb mux SHALL be the state registered alongside stage 1, so overlay visibility changes only at a frame boundary, never mid-frame.
REQ-016 The rectangle table SHALL be writable in every state. A change SHALL affect hits from the next stage-1 evaluation.

Reset
REQ-017 On rst: all out fields SHALL be 0, both pipeline stages 0, state IDLE, win_q 0, frame counter 0, every rect_en 0 and every bound 0.
REQ-018 reset (game restart) SHALL NOT clear the rectangle table.

Verification
REQ-019 Pipeline: feed hcount = 100, vcount = 50, rgb = 12'hABC with gameover = 0 -> out shows the same values 2 cycles later; rgb = 12'hABC.
REQ-020 Hit edges: rect0 = (10, 20, 10, 20) enabled, gameover = 2'b01, after a frame boundary:
- (15, 15) -> 12'h820.
- (10, 15) and (20, 15) -> in.rgb (strict bounds).
REQ-021 Blink, BLINK_FRAMES = 2: after arming, overlay visible for frames 1-2, hidden for frames 3-4, visible again for frame 5. No rgb change occurs while vblnk = 0 within a frame.
REQ-022 Latch: gameover = 2'b10 then 2'b01 mid-show -> colour stays 12'h028. Then reset = 1 together with gameover = 2'b11 -> IDLE, overlay off. Next cycle gameover = 2'b11 held -> ARMED; after a frame boundary the colour is 12'h888.
REQ-023 Table writes:
- rect_idx = NUM_RECT with rect_we -> no entry changes.
- Writing rect_en = 0 to a hitting rect during SHOW_ON -> overlay disappears 2 cycles after the write edge.
- Asserting rst mid-show -> all outputs 0 next cycle, table cleared.

Source files
------------

// File: rtl/draw_end_banner_if.sv
// VGA pixel-stream bundle: raster timing fields plus 12-bit colour.
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_end_banner.sv
// End-of-game banner overlay: a two-stage pixel pipeline that paints the
// winner's colour over a programmable set of rectangles, blinking per frame.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | game running, no overlay, waiting for a non-zero gameover
// ARMED    | winner latched, waiting for the next frame to start showing
// SHOW_ON  | overlay drawn on hitting rectangles
// SHOW_OFF | overlay hidden for this blink phase
module draw_end_banner #(
    parameter int          NUM_RECT     = 8,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [11:0] COLOR_P1     = 12'h820,
    parameter logic [11:0] COLOR_P2     = 12'h028,
    parameter logic [11:0] COLOR_DRAW   = 12'h888
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        reset,
    input  logic [1:0]                  gameover,
    input  logic                        rect_we,
    input  logic [$clog2(NUM_RECT)-1:0] rect_idx,
    input  logic                        rect_en,
    input  logic [10:0]                 rect_x0,
    input  logic [10:0]                 rect_x1,
    input  logic [10:0]                 rect_y0,
    input  logic [10:0]                 rect_y1,
    vga_if.in                           in,
    vga_if.out                          out
);

    localparam int IW = $clog2(NUM_RECT);
    localparam int CW = ($clog2(BLINK_FRAMES + 1) > 0) ? $clog2(BLINK_FRAMES + 1) : 1;
    // With blinking disabled the terminal count is never consulted.
    localparam logic [CW-1:0] CNT_LAST = (BLINK_FRAMES > 0) ? CW'(BLINK_FRAMES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        SHOW_ON  = 2'd2,
        SHOW_OFF = 2'd3
    } state_t;

    typedef struct packed {
        logic        en;
        logic [10:0] x0;
        logic [10:0] x1;
        logic [10:0] y0;
        logic [10:0] y1;
    } rect_t;

    typedef struct packed {
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
    } timing_t;

    state_t                state_q, state_d;
    logic [1:0]            win_q, win_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    rect_t                 rect_q [NUM_RECT];
    rect_t                 rect_d [NUM_RECT];

    timing_t               tim1_q, tim1_d;
    logic [11:0]           rgb1_q, rgb1_d;
    logic [NUM_RECT-1:0]   hit1_q, hit1_d;
    state_t                state1_q, state1_d;
    logic [1:0]            win1_q, win1_d;

    timing_t               tim2_q, tim2_d;
    logic [11:0]           rgb2_q, rgb2_d;

    logic                  frame_edge;
    logic [11:0]           banner_rgb;

    // Stage 1 holds last cycle's vblnk, so it doubles as the edge detector.
    assign frame_edge = in.vblnk & ~tim1_q.vblnk;

    // Rectangle table update; out-of-range indices match no entry.
    always_comb begin
        rect_d = rect_q;
        for (int i = 0; i < NUM_RECT; i++) begin
            if (rect_we && (rect_idx == IW'(i))) begin
                rect_d[i] = '{en: rect_en, x0: rect_x0, x1: rect_x1,
                              y0: rect_y0, y1: rect_y1};
            end
        end
    end

    // Banner sequencing: latch the winner, then blink on frame boundaries.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        if (reset) begin
            state_d = IDLE;
            win_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gameover != 2'b00) begin
                        state_d = ARMED;
                        win_d   = gameover;
                    end
                end
                ARMED: begin
                    if (frame_edge) begin
                        state_d = SHOW_ON;
                        cnt_d   = '0;
                    end
                end
                SHOW_ON, SHOW_OFF: begin
                    if (frame_edge && (BLINK_FRAMES > 0)) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            state_d = (state_q == SHOW_ON) ? SHOW_OFF : SHOW_ON;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Stage 1: capture timing, colour, per-rectangle hits and the control state.
    always_comb begin
        tim1_d   = '{vcount: in.vcount, vsync: in.vsync, vblnk: in.vblnk,
                     hcount: in.hcount, hsync: in.hsync, hblnk: in.hblnk};
        rgb1_d   = in.rgb;
        state1_d = state_q;
        win1_d   = win_q;
        hit1_d   = '0;
        for (int i = 0; i < NUM_RECT; i++) begin
            hit1_d[i] = rect_q[i].en
                      && (rect_q[i].x0 < in.hcount) && (in.hcount < rect_q[i].x1)
                      && (rect_q[i].y0 < in.vcount) && (in.vcount < rect_q[i].y1);
        end
    end

    // Stage 2: overlay the winner's colour when visible and any rectangle hits.
    always_comb begin
        tim2_d = tim1_q;
        case (win1_q)
            2'b01:   banner_rgb = COLOR_P1;
            2'b10:   banner_rgb = COLOR_P2;
            2'b11:   banner_rgb = COLOR_DRAW;
            default: banner_rgb = rgb1_q;
        endcase
        rgb2_d = ((state1_q == SHOW_ON) && (|hit1_q)) ? banner_rgb : rgb1_q;
    end

    // All registers, cleared together by the synchronous system reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            win_q    <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < NUM_RECT; i++) begin
                rect_q[i] <= '0;
            end
            tim1_q   <= '0;
            rgb1_q   <= '0;
            hit1_q   <= '0;
            state1_q <= IDLE;
            win1_q   <= '0;
            tim2_q   <= '0;
            rgb2_q   <= '0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            cnt_q    <= cnt_d;
            rect_q   <= rect_d;
            tim1_q   <= tim1_d;
            rgb1_q   <= rgb1_d;
            hit1_q   <= hit1_d;
            state1_q <= state1_d;
            win1_q   <= win1_d;
            tim2_q   <= tim2_d;
            rgb2_q   <= rgb2_d;
        end
    end

    assign out.vcount = tim2_q.vcount;
    assign out.vsync  = tim2_q.vsync;
    assign out.vblnk  = tim2_q.vblnk;
    assign out.hcount = tim2_q.hcount;
    assign out.hsync  = tim2_q.hsync;
    assign out.hblnk  = tim2_q.hblnk;
    assign out.rgb    = rgb2_q;

endmodule

// File: tb/tb_draw_end_banner.sv
// Bench for draw_end_banner: directed scenarios plus a randomized raster,
// every cycle compared against a frame-level reference model.
module tb_draw_end_banner;

    localparam int NR = 6;
    localparam int BF = 2;
    localparam int H  = 24;
    localparam int V  = 16;
    localparam logic [11:0] C_P1 = 12'h820;
    localparam logic [11:0] C_P2 = 12'h028;
    localparam logic [11:0] C_DR = 12'h888;

    typedef struct packed {
        logic [10:0] vc;
        logic        vs;
        logic        vb;
        logic [10:0] hc;
        logic        hs;
        logic        hb;
        logic [11:0] rgb;
    } px_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reset = 1'b0;
    logic [1:0]  gameover = 2'b00;
    logic        rect_we = 1'b0;
    logic [2:0]  rect_idx = '0;
    logic        rect_en = 1'b0;
    logic [10:0] rect_x0 = '0, rect_x1 = '0, rect_y0 = '0, rect_y1 = '0;

    vga_if vin ();
    vga_if vout ();

    draw_end_banner #(
        .NUM_RECT(NR), .BLINK_FRAMES(BF),
        .COLOR_P1(C_P1), .COLOR_P2(C_P2), .COLOR_DRAW(C_DR)
    ) dut (
        .clk(clk), .rst(rst), .reset(reset), .gameover(gameover),
        .rect_we(rect_we), .rect_idx(rect_idx), .rect_en(rect_en),
        .rect_x0(rect_x0), .rect_x1(rect_x1), .rect_y0(rect_y0), .rect_y1(rect_y1),
        .in(vin), .out(vout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: mode 0 idle, 1 armed, 2 showing; nfr = frame boundaries since show began.
    int          m_mode = 0;
    int          m_nfr  = 0;
    logic [1:0]  m_win  = 0;
    logic        m_prev = 0;
    logic        m_en [NR];
    logic [10:0] m_x0 [NR], m_x1 [NR], m_y0 [NR], m_y1 [NR];
    px_t         m_p1 = '0;
    px_t         exp_out = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic model_clear_table();
        for (int i = 0; i < NR; i++) begin
            m_en[i] = 0; m_x0[i] = 0; m_x1[i] = 0; m_y0[i] = 0; m_y1[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit          hit;
        bit          vis;
        bit          bnd;
        logic [11:0] col;
        if (rst) begin
            exp_out = '0; m_p1 = '0; m_prev = 0;
            m_mode = 0; m_win = 0; m_nfr = 0;
            model_clear_table();
        end else begin
            exp_out = m_p1;
            hit = 0;
            for (int i = 0; i < NR; i++)
                if (m_en[i] && m_x0[i] < vin.hcount && vin.hcount < m_x1[i]
                            && m_y0[i] < vin.vcount && vin.vcount < m_y1[i]) hit = 1;
            vis = (m_mode == 2) && ((m_nfr / BF) % 2 == 0);
            col = (m_win == 2'b01) ? C_P1 : (m_win == 2'b10) ? C_P2 : C_DR;
            m_p1 = '{vc: vin.vcount, vs: vin.vsync, vb: vin.vblnk, hc: vin.hcount,
                     hs: vin.hsync, hb: vin.hblnk, rgb: (vis && hit) ? col : vin.rgb};
            bnd = vin.vblnk && !m_prev;
            m_prev = vin.vblnk;
            if (reset) begin
                m_mode = 0; m_win = 0; m_nfr = 0;
            end else if (m_mode == 0) begin
                if (gameover != 2'b00) begin m_mode = 1; m_win = gameover; end
            end else if (m_mode == 1) begin
                if (bnd) begin m_mode = 2; m_nfr = 0; end
            end else begin
                if (bnd) m_nfr++;
            end
            if (rect_we && rect_idx < NR) begin
                m_en[rect_idx] = rect_en;
                m_x0[rect_idx] = rect_x0; m_x1[rect_idx] = rect_x1;
                m_y0[rect_idx] = rect_y0; m_y1[rect_idx] = rect_y1;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_val("timing", {6'd0, vout.vcount, vout.vsync, vout.vblnk, vout.hcount, vout.hsync, vout.hblnk},
                  {6'd0, exp_out.vc, exp_out.vs, exp_out.vb, exp_out.hc, exp_out.hs, exp_out.hb});
        check_val("rgb", {20'd0, vout.rgb}, {20'd0, exp_out.rgb});
    endtask

    task automatic set_px(input int h, input int v, input bit vb, input logic [11:0] c);
        vin.hcount = 11'(h); vin.vcount = 11'(v); vin.vblnk = vb;
        vin.hblnk = 0; vin.hsync = 0; vin.vsync = 0; vin.rgb = c;
    endtask

    task automatic probe(input string tag, input int h, input int v, input logic [11:0] c,
                         input logic [11:0] exp_rgb);
        set_px(h, v, 0, c);
        tick();
        set_px(0, 0, 0, 12'h000);
        tick();
        check_val(tag, {20'd0, vout.rgb}, {20'd0, exp_rgb});
    endtask

    task automatic boundary();
        set_px(0, 0, 0, 12'h000); tick();
        set_px(0, 0, 1, 12'h000); tick();
        set_px(0, 0, 0, 12'h000); tick();
    endtask

    task automatic write_rect(input int idx, input bit en, input int x0, input int x1,
                              input int y0, input int y1);
        rect_we = 1; rect_idx = 3'(idx); rect_en = en;
        rect_x0 = 11'(x0); rect_x1 = 11'(x1); rect_y0 = 11'(y0); rect_y1 = 11'(y1);
        tick();
        rect_we = 0;
    endtask

    task automatic pulse_go(input logic [1:0] g);
        gameover = g; tick(); gameover = 2'b00;
    endtask

    task automatic pulse_reset();
        reset = 1; tick(); reset = 0;
    endtask

    task automatic random_frame();
        for (int v = 0; v < V; v++) begin
            for (int h = 0; h < H; h++) begin
                vin.hcount = 11'(h); vin.vcount = 11'(v);
                vin.hblnk = (h >= 20); vin.hsync = (h >= 21 && h < 23);
                vin.vblnk = (v >= 13); vin.vsync = (v == 14);
                vin.rgb = 12'($urandom);
                rect_we = ($urandom_range(0, 99) < 3);
                rect_idx = 3'($urandom_range(0, 7));
                rect_en = ($urandom_range(0, 3) != 0);
                rect_x0 = 11'($urandom_range(0, 25)); rect_x1 = 11'($urandom_range(0, 25));
                rect_y0 = 11'($urandom_range(0, 17)); rect_y1 = 11'($urandom_range(0, 17));
                gameover = ($urandom_range(0, 299) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                reset = ($urandom_range(0, 2999) == 0);
                tick();
            end
        end
        rect_we = 0; gameover = 2'b00; reset = 0;
    endtask

    initial begin
        model_clear_table();
        set_px(7, 9, 1, 12'hFFF);
        rst = 1;
        repeat (3) tick();
        check_val("rst_out", {vout.rgb, vout.hcount, vout.vblnk}, 32'd0);
        rst = 0;

        // Plain pass-through with two cycles of latency.
        set_px(100, 50, 0, 12'hABC); tick();
        set_px(0, 0, 0, 12'h000);    tick();
        check_val("pipe_h", {21'd0, vout.hcount}, 32'd100);
        check_val("pipe_v", {21'd0, vout.vcount}, 32'd50);
        check_val("pipe_rgb", {20'd0, vout.rgb}, 32'hABC);

        // Out-of-range writes must not land anywhere.
        write_rect(0, 1, 10, 20, 10, 20);
        write_rect(NR, 1, 0, 2047, 0, 2047);
        write_rect(7, 1, 0, 2047, 0, 2047);
        pulse_go(2'b01);
        probe("armed_hidden", 15, 15, 12'h5A5, 12'h5A5);
        boundary();
        probe("hit_mid", 15, 15, 12'h5A5, C_P1);
        probe("hit_x0", 10, 15, 12'h5A5, 12'h5A5);
        probe("hit_x1", 20, 15, 12'h5A5, 12'h5A5);
        probe("hit_y1", 15, 20, 12'h5A5, 12'h5A5);
        probe("oob_idx", 100, 100, 12'h123, 12'h123);

        // Blink with two frames per phase.
        boundary(); probe("blink_f2", 15, 15, 12'h5A5, C_P1);
        boundary(); probe("blink_f3", 15, 15, 12'h5A5, 12'h5A5);
        boundary(); probe("blink_f4", 15, 15, 12'h5A5, 12'h5A5);
        boundary(); probe("blink_f5", 15, 15, 12'h5A5, C_P1);

        // Winner latch and game restart priority.
        pulse_reset();
        probe("restart_off", 15, 15, 12'h5A5, 12'h5A5);
        pulse_go(2'b10);
        boundary();
        probe("latch_p2", 15, 15, 12'h5A5, C_P2);
        pulse_go(2'b01);
        probe("latch_hold", 15, 15, 12'h5A5, C_P2);
        reset = 1; gameover = 2'b11; tick();
        reset = 0; tick();
        gameover = 2'b00;
        probe("rearm_hidden", 15, 15, 12'h5A5, 12'h5A5);
        boundary();
        probe("draw_col", 15, 15, 12'h5A5, C_DR);

        // Disabling a hitting rectangle mid-show.
        set_px(15, 15, 0, 12'h111);
        write_rect(0, 0, 10, 20, 10, 20);
        tick();
        check_val("dis_w1", {20'd0, vout.rgb}, {20'd0, C_DR});
        tick();
        check_val("dis_w2", {20'd0, vout.rgb}, 32'h111);

        // Randomized raster against the model.
        for (int f = 0; f < 24; f++) random_frame();

        // System reset while showing clears outputs and the table.
        write_rect(0, 1, 10, 20, 10, 20);
        pulse_reset();
        pulse_go(2'b01);
        boundary();
        probe("preshow", 15, 15, 12'h5A5, C_P1);
        set_px(15, 15, 0, 12'hFFF);
        rst = 1; tick();
        check_val("rst_mid", {vout.rgb, vout.hcount, vout.vcount[8:0]}, 32'd0);
        rst = 0;
        pulse_go(2'b01);
        boundary();
        probe("tbl_cleared", 15, 15, 12'h3C3, 12'h3C3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
